// File: rtl/vxc_pkg.sv
// vxc_pkg: shared definitions for the VXC row feeder.
//   - element width / lane count defaults
//   - vxc_rows(): ceil(elements / lanes), number of rows per vector pass
//   - vxc_feeder_state_e: feeder FSM state encoding
package vxc_pkg;

  localparam int VXC_ELEMENT_WIDTH = 64;
  localparam int VXC_NO_OF_UNITS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } vxc_feeder_state_e;

  function automatic int vxc_rows(input int n_elem, input int n_units);
    return (n_elem + n_units - 1) / n_units;
  endfunction

endpackage

// File: rtl/vxc_lane_mask.sv
// vxc_lane_mask: combinational lane-valid mask for one row.
//   Bit k is set when the global element index row*no_of_units+k lies
//   inside the vector (< number_of_equations_per_cluster).
// Ports:
//   i_row  [addr_width-1:0]   row index being loaded
//   o_mask [no_of_units-1:0]  1 = lane carries a real element
module vxc_lane_mask #(
  parameter int number_of_equations_per_cluster = 19,
  parameter int no_of_units                     = 8,
  parameter int addr_width                      = 8
) (
  input  logic [addr_width-1:0]  i_row,
  output logic [no_of_units-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    for (int k = 0; k < no_of_units; k++) begin
      o_mask[k] = ((int'(i_row) * no_of_units + k) < number_of_equations_per_cluster);
    end
  end

endmodule

// File: rtl/vxc_row_feeder.sv
// vxc_row_feeder: walks a vector through two synchronous row memories,
// presenting one row pair at a time to a consumer that requests the
// next row with read_again.
// Optional feature macro: VXC_FEEDER_PAD_ZERO_EN -- when defined, lanes
// beyond the vector length in the last row are forced to zero.
// Ports:
//   clk, reset (async active-high)
//   start             begin a pass (ignored while busy)
//   read_again        consumer latched the row, wants the next one
//   mem_re, mem_addr  read strobe / row address for both memories
//   mem_a_rdata, mem_b_rdata  RAM data, valid 1 cycle after mem_re
//   first_row_fixed, second_row_fixed  presented rows (held when not valid)
//   row_valid, busy, done, overrun (sticky read_again-while-not-valid)
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | mem_re asserted for the current row address
// LOAD    | RAM data valid, captured into the row registers
// PRESENT | rows valid, waiting for read_again
// DONE    | all rows consumed, waiting for a new start
module vxc_row_feeder
  import vxc_pkg::*;
#(
  parameter int number_of_equations_per_cluster = 19,
  parameter int element_width                   = VXC_ELEMENT_WIDTH,
  parameter int no_of_units                     = VXC_NO_OF_UNITS,
  parameter int addr_width                      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 read_again,
  output logic                                 mem_re,
  output logic [addr_width-1:0]                mem_addr,
  input  logic [element_width*no_of_units-1:0] mem_a_rdata,
  input  logic [element_width*no_of_units-1:0] mem_b_rdata,
  output logic [element_width*no_of_units-1:0] first_row_fixed,
  output logic [element_width*no_of_units-1:0] second_row_fixed,
  output logic                                 row_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overrun
);

  localparam int ROW_W = element_width * no_of_units;
  localparam int ROWS  = vxc_rows(number_of_equations_per_cluster, no_of_units);
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(ROWS - 1);

  vxc_feeder_state_e r_state, w_state_nxt;
  logic [addr_width-1:0] r_addr, w_addr_nxt;
  logic                  r_overrun, w_overrun_nxt;
  logic [ROW_W-1:0]      r_row_a, r_row_b;
  logic [ROW_W-1:0]      w_row_a, w_row_b;

`ifdef VXC_FEEDER_PAD_ZERO_EN
  logic [no_of_units-1:0] w_lane_mask;

  vxc_lane_mask #(
    .number_of_equations_per_cluster(number_of_equations_per_cluster),
    .no_of_units                    (no_of_units),
    .addr_width                     (addr_width)
  ) u_lane_mask (
    .i_row  (r_addr),
    .o_mask (w_lane_mask)
  );

  always_comb begin
    w_row_a = '0;
    w_row_b = '0;
    for (int k = 0; k < no_of_units; k++) begin
      w_row_a[k*element_width +: element_width] =
        w_lane_mask[k] ? mem_a_rdata[k*element_width +: element_width] : '0;
      w_row_b[k*element_width +: element_width] =
        w_lane_mask[k] ? mem_b_rdata[k*element_width +: element_width] : '0;
    end
  end
`else
  assign w_row_a = mem_a_rdata;
  assign w_row_b = mem_b_rdata;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_overrun_nxt = r_overrun;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // start has priority over read_again, which is a no-op here
        if (start) begin
          w_state_nxt   = ST_FETCH;
          w_addr_nxt    = '0;
          w_overrun_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        if (read_again) w_overrun_nxt = 1'b1;
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (read_again) w_overrun_nxt = 1'b1;
        w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (read_again) begin
          if (r_addr == LAST_ADDR) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FETCH;
            w_addr_nxt  = r_addr + addr_width'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_overrun <= 1'b0;
      r_row_a   <= '0;
      r_row_b   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_overrun <= w_overrun_nxt;
      if (r_state == ST_LOAD) begin
        r_row_a <= w_row_a;
        r_row_b <= w_row_b;
      end
    end
  end

  // Strobes are decoded from the state register, so each one changes on
  // the same edge as the transition that defines it.
  assign mem_re           = (r_state == ST_FETCH);
  assign mem_addr         = r_addr;
  assign row_valid        = (r_state == ST_PRESENT);
  assign busy             = (r_state == ST_FETCH) || (r_state == ST_LOAD) ||
                            (r_state == ST_PRESENT);
  assign done             = (r_state == ST_DONE);
  assign overrun          = r_overrun;
  assign first_row_fixed  = r_row_a;
  assign second_row_fixed = r_row_b;

endmodule

// File: tb/tb_vxc_row_feeder.sv
// Testbench for vxc_row_feeder: synchronous RAM model, address/row
// scoreboard and directed sequencing checks.
module tb_vxc_row_feeder;

  localparam int EW   = 64;
  localparam int NU   = 8;
  localparam int AW   = 8;
  localparam int NEQ  = 19;
  localparam int W    = EW * NU;
  localparam int ROWS = 3;
`ifdef VXC_FEEDER_PAD_ZERO_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, read_again;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_a_rdata, mem_b_rdata;
  logic [W-1:0]  first_row_fixed, second_row_fixed;
  logic          row_valid, busy, done, overrun;

  vxc_row_feeder #(
    .number_of_equations_per_cluster(NEQ),
    .element_width(EW),
    .no_of_units(NU),
    .addr_width(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .read_again(read_again),
    .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
    .first_row_fixed(first_row_fixed), .second_row_fixed(second_row_fixed),
    .row_valid(row_valid), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem_a [0:255];
  logic [W-1:0] mem_b [0:255];

  always @(posedge clk) begin
    if (mem_re) begin
      mem_a_rdata <= mem_a[mem_addr];
      mem_b_rdata <= mem_b[mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pad_model(input logic [W-1:0] w, input int row);
    logic [W-1:0] r;
    r = w;
    for (int k = 0; k < NU; k++)
      if (PAD_ON && (row * NU + k >= NEQ)) r[k*EW +: EW] = '0;
    return r;
  endfunction

  // scoreboard
  int           exp_addr_q[$];
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int           fetch_cnt = 0;
  logic         prev_valid = 1'b0;
  int           ea;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_re) begin
        fetch_cnt++;
        check_val("fetch_expected", W'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          check_val("fetch_addr", W'(mem_addr), W'(ea));
          exp_a_q.push_back(pad_model(mem_a[ea], ea));
          exp_b_q.push_back(pad_model(mem_b[ea], ea));
        end
      end
      if (row_valid && !prev_valid) begin
        check_val("row_expected", W'(exp_a_q.size() > 0), 1);
        if (exp_a_q.size() > 0) begin
          check_val("row_a", first_row_fixed, exp_a_q.pop_front());
          check_val("row_b", second_row_fixed, exp_b_q.pop_front());
        end
      end
    end
    prev_valid = row_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    exp_addr_q.push_back(0);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!row_valid && n < 20) begin
      tick();
      n++;
    end
    check_val("row_valid_wait", W'(row_valid), 1);
  endtask

  task automatic consume(input int row);
    wait_valid();
    if (row < ROWS - 1) exp_addr_q.push_back(row + 1);
    read_again = 1'b1;
    tick();
    read_again = 1'b0;
    check_val("valid_drop", W'(row_valid), 0);
    if (row == ROWS - 1) begin
      check_val("done_last", W'(done), 1);
      check_val("busy_last", W'(busy), 0);
    end else begin
      check_val("next_fetch_re", W'(mem_re), 1);
    end
  endtask

  task automatic run_pass();
    for (int r = 0; r < ROWS; r++) consume(r);
  endtask

  task automatic fill_distinct();
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < NU; k++) begin
        mem_a[i][k*EW +: EW] = {32'hA000_0000 | 32'(i), 32'h0000_1000 | 32'(k)};
        mem_b[i][k*EW +: EW] = {32'hB000_0000 | 32'(i), 32'h0000_2000 | 32'(k)};
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_mem_re"},    W'(mem_re), 0);
    check_val({tag, "_mem_addr"},  W'(mem_addr), 0);
    check_val({tag, "_row_a"},     first_row_fixed, 0);
    check_val({tag, "_row_b"},     second_row_fixed, 0);
    check_val({tag, "_row_valid"}, W'(row_valid), 0);
    check_val({tag, "_busy"},      W'(busy), 0);
    check_val({tag, "_done"},      W'(done), 0);
    check_val({tag, "_overrun"},   W'(overrun), 0);
  endtask

  logic [EW-1:0] lane_ff;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    read_again = 1'b0;
    mem_a_rdata = '0;
    mem_b_rdata = '0;
    fill_distinct();
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // first pass: latency, start-while-busy, full consumption
    do_start();
    check_val("c1_mem_re", W'(mem_re), 1);
    check_val("c1_addr", W'(mem_addr), 0);
    check_val("c1_busy", W'(busy), 1);
    check_val("c1_valid", W'(row_valid), 0);
    tick();
    check_val("c2_mem_re", W'(mem_re), 0);
    check_val("c2_valid", W'(row_valid), 0);
    tick();
    check_val("c3_valid", W'(row_valid), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("busy_start_re", W'(mem_re), 0);
    check_val("busy_start_valid", W'(row_valid), 1);
    check_val("busy_start_addr", W'(mem_addr), 0);
    run_pass();
    repeat (5) tick();
    check_val("fetch_count", W'(fetch_cnt), 3);
    check_val("done_hold", W'(done), 1);
    check_val("addr_no_wrap", W'(mem_addr), 2);
    check_val("hold_row_a", first_row_fixed, pad_model(mem_a[2], 2));
    read_again = 1'b1;
    tick();
    read_again = 1'b0;
    check_val("ra_in_done", W'(done), 1);
    check_val("ra_in_done_re", W'(mem_re), 0);
    check_val("ra_in_done_ovr", W'(overrun), 0);

    // padding pass with all-ones memory
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '1;
      mem_b[i] = '1;
    end
    do_start();
    run_pass();
    lane_ff = '1;
    check_val("pad_a_lane2", W'(first_row_fixed[2*EW +: EW]), W'(lane_ff));
    check_val("pad_b_lane2", W'(second_row_fixed[2*EW +: EW]), W'(lane_ff));
    check_val("pad_a_lane3", W'(first_row_fixed[3*EW +: EW]), PAD_ON ? '0 : W'(lane_ff));
    check_val("pad_b_lane7", W'(second_row_fixed[7*EW +: EW]), PAD_ON ? '0 : W'(lane_ff));
    fill_distinct();

    // overrun: read_again during LOAD
    do_start();
    tick();
    read_again = 1'b1;
    tick();
    read_again = 1'b0;
    check_val("ovr_set", W'(overrun), 1);
    check_val("ovr_valid", W'(row_valid), 1);
    check_val("ovr_no_skip", W'(mem_addr), 0);
    run_pass();
    check_val("ovr_sticky", W'(overrun), 1);

    // start and read_again together in DONE
    exp_addr_q.push_back(0);
    start = 1'b1;
    read_again = 1'b1;
    tick();
    start = 1'b0;
    read_again = 1'b0;
    check_val("sr_done", W'(done), 0);
    check_val("sr_mem_re", W'(mem_re), 1);
    check_val("sr_addr", W'(mem_addr), 0);
    check_val("sr_ovr_clr", W'(overrun), 0);

    // reset in PRESENT of row 1
    consume(0);
    wait_valid();
    check_val("mid_addr", W'(mem_addr), 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    exp_addr_q.delete();
    exp_a_q.delete();
    exp_b_q.delete();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_val("post_rst_idle_re", W'(mem_re), 0);
    check_val("post_rst_idle_busy", W'(busy), 0);
    do_start();
    check_val("refetch_re", W'(mem_re), 1);
    check_val("refetch_addr", W'(mem_addr), 0);
    run_pass();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vxc_row_feeder.md
VXC_ROW_FEEDER -- requirements
Module: vxc_row_feeder

Interface
REQ-001 SHALL have parameter number_of_equations_per_cluster, default 19, the valid element count per vector.
REQ-002 SHALL have parameter element_width, default 64, the complex element width in bits.
REQ-003 SHALL have parameter no_of_units, default 8, the number of lanes per row.
REQ-004 SHALL have parameter addr_width, default 8, the row-address width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high: clk input 1 bit (rising-edge clock) and reset input 1 bit (async active-high reset).
REQ-006 start, input, 1 bit: begin a vector pass.
REQ-007 read_again, input, 1 bit: consumer has latched the current row and requests the next one.
REQ-008 mem_re, output, 1 bit: read strobe to both row memories.
REQ-009 mem_addr, output, addr_width bits: row address shared by both memories.
REQ-010 mem_a_rdata and mem_b_rdata, inputs, element_width*no_of_units bits each: synchronous RAM data, valid 1 cycle after mem_re.
REQ-011 first_row_fixed and second_row_fixed, outputs, element_width*no_of_units bits each: the presented rows.
REQ-012 row_valid, output, 1 bit: presented rows are valid.
REQ-013 busy, output, 1 bit: a pass is in progress.
REQ-014 done, output, 1 bit: the pass is complete.
REQ-015 overrun, output, 1 bit: sticky flag for a read_again received while row_valid=0 during busy.

Function
REQ-016 SHALL process rows = ceil(number_of_equations_per_cluster/no_of_units), which is 3 for the defaults.
REQ-017 SHALL pack lane k at bits [k*element_width +: element_width]; lane 0 holds the lowest element index.
REQ-018 SHALL implement the states IDLE, FETCH, LOAD, PRESENT and DONE.
REQ-019 IDLE: start=1 -> FETCH, with mem_re=1 and mem_addr=0 registered on the same edge.
REQ-020 FETCH -> LOAD unconditionally, with mem_re=0.
REQ-021 LOAD SHALL register both rdata buses into the row outputs -> PRESENT, with row_valid=1 on that edge.
REQ-022 The latency from start sampled to row_valid=1 SHALL be exactly 2 cycles.
REQ-023 PRESENT with read_again=1 and rows remaining -> FETCH with mem_addr+1 and mem_re=1; row_valid SHALL drop on the same edge.
REQ-024 PRESENT with read_again=1 on the last row -> DONE, with row_valid=0, done=1 and busy=0.
REQ-025 The row outputs SHALL hold their last value whenever row_valid=0.
REQ-026 read_again in IDLE, FETCH, LOAD or DONE SHALL not change state; in FETCH or LOAD it SHALL set overrun.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 start in DONE SHALL clear done and behave as start from IDLE; overrun SHALL clear only on reset or on an accepted start.
REQ-029 start and read_again together in DONE: start SHALL win.
REQ-030 busy SHALL be 1 in FETCH, LOAD and PRESENT only.
REQ-031 mem_addr SHALL never exceed rows-1 and SHALL never wrap.

Reset
REQ-032 Asynchronous reset SHALL set state=IDLE, mem_re=0, mem_addr=0, both row outputs to 0, row_valid=0, busy=0, done=0 and overrun=0.
REQ-033 Reset asserted mid-pass SHALL abort the pass immediately; after release the block SHALL wait for a new start.

Configuration
REQ-034 Macro VXC_FEEDER_PAD_ZERO_EN defined: in LOAD, lanes whose global index row*no_of_units+k >= number_of_equations_per_cluster SHALL be forced to 0 in both outputs (lanes 3..7 of row 2 for the defaults).
REQ-035 Macro VXC_FEEDER_PAD_ZERO_EN undefined: memory data SHALL pass unmodified.

Structure
REQ-036 Package vxc_pkg SHALL hold the element_width and no_of_units defaults, the rows ceil function and the feeder state enum.
REQ-037 Sub-module vxc_lane_mask SHALL be combinational: it takes the row index and produces the no_of_units-bit lane-valid mask used for padding.

Verification
REQ-038 reset -> start pulse at cycle 0 -> mem_re=1 with addr 0 at cycle 1, and row_valid=1 at cycle 3 with rows equal to memory word 0.
REQ-039 With read_again held to consume 3 rows -> addresses 0,1,2 are issued, and done=1 with busy=0 after the third read_again; no fourth mem_re occurs.
REQ-040 With PAD_EN, all memory words 0xFF.. -> row 2 lanes 0-2 read 0xFF.. and lanes 3-7 read 0, in both outputs; without PAD_EN, all lanes read 0xFF...
REQ-041 read_again pulsed in LOAD -> overrun=1 and no address skip; the next start clears overrun.
REQ-042 reset asserted in PRESENT of row 1 -> all outputs are 0 immediately; start after release refetches from addr 0.
REQ-043 start and read_again together in DONE -> a new pass begins at addr 0 and done=0 on the next edge.
